// File: rtl/me_pkg.sv
// Shared constants for the ME result reader: address width, word-type codes,
// FIFO word widths, counter limits and the reader FSM state encoding.
package me_pkg;

  localparam int MSBI  = 13;
  localparam int VEC_W = 30;
  localparam int IMG_W = 26;
  localparam int CNT_W = 14;

  localparam logic [1:0] WT_VEC = 2'b01;
  localparam logic [1:0] WT_PIX = 2'b10;
  localparam logic [1:0] WT_TRL = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_POP_VEC,
    S_CAP_VEC,
    S_POP_IMG,
    S_CAP_IMG,
    S_SEND,
    S_TRAILER,
    S_DONE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/me_out_stage.sv
// Single-entry output holding register: a loaded word stays on out_data with
// its sop/eop flags until the consumer accepts it with out_ready.
module me_out_stage (
  input  logic        clk_fsm,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        load_sop,
  input  logic        load_eop,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        fire
);

  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (valid_q && out_ready) begin
      data_d  = '0;
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
      sop_d   = load_sop;
      eop_d   = load_eop;
    end
  end

  always_ff @(posedge clk_fsm or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign fire      = valid_q & out_ready;

endmodule

// File: rtl/me_result_reader.sv
// Drains the vector and pixel FIFOs after a search and streams them out framed by
// sop/eop plus a counting trailer. Optional frame-tag check: ME_READER_TAG_CHECK_EN.
module me_result_reader #(
  parameter int MSBI = me_pkg::MSBI
) (
  input  logic                      clk_fsm,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      search_finish,
  input  logic                      vec_fifo_empty,
  output logic                      vec_fifo_rd_req,
  input  logic [2*MSBI+3:0]         vec_fifo_q,
  input  logic                      img_fifo_empty,
  output logic                      img_fifo_rd_req,
  input  logic [me_pkg::IMG_W-1:0]  img_fifo_q,
  output logic [31:0]               out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [13:0]               vec_count,
  output logic [13:0]               px_count,
  output logic                      idle,
  output logic                      tag_err
);
  import me_pkg::*;

  state_t           state_q, state_d;
  logic             vec_rd_q, vec_rd_d;
  logic             img_rd_q, img_rd_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] px_cnt_q, px_cnt_d;
  logic [1:0]       frame_tag_q, frame_tag_d;
  logic [1:0]       wtype_q, wtype_d;
  logic             tag_valid_q, tag_valid_d;
  logic             sop_pending_q, sop_pending_d;
  logic             finish_seen_q, finish_seen_d;
`ifdef ME_READER_TAG_CHECK_EN
  logic             tag_err_q, tag_err_d;
`endif

  logic        ld, ld_eop, fire;
  logic [31:0] ld_data;
  logic [1:0]  cap_img;
  logic [31:0] cap_word;

  // FIFO q is valid in CAP_x, one cycle after the POP_x read request.
  assign cap_img  = (state_q == S_CAP_VEC) ? vec_fifo_q[2*MSBI+3 -: 2] : img_fifo_q[25:24];
  assign cap_word = (state_q == S_CAP_VEC) ? {WT_VEC, vec_fifo_q}
                                           : {WT_PIX, img_fifo_q[25:24], 4'b0000, img_fifo_q[23:0]};

  always_comb begin
    state_d       = state_q;
    vec_rd_d      = 1'b0;
    img_rd_d      = 1'b0;
    vec_cnt_d     = vec_cnt_q;
    px_cnt_d      = px_cnt_q;
    frame_tag_d   = frame_tag_q;
    wtype_d       = wtype_q;
    tag_valid_d   = tag_valid_q;
    sop_pending_d = sop_pending_q;
    finish_seen_d = finish_seen_q;
`ifdef ME_READER_TAG_CHECK_EN
    tag_err_d     = tag_err_q;
`endif
    ld            = 1'b0;
    ld_eop        = 1'b0;
    ld_data       = '0;

    if (state_q != S_IDLE && search_finish) finish_seen_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_ARB;
          vec_cnt_d     = '0;
          px_cnt_d      = '0;
          frame_tag_d   = 2'b00;
          tag_valid_d   = 1'b0;
          sop_pending_d = 1'b1;
          finish_seen_d = 1'b0;
`ifdef ME_READER_TAG_CHECK_EN
          tag_err_d     = 1'b0;
`endif
        end
      end
      S_ARB: begin
        if (!vec_fifo_empty) begin
          state_d  = S_POP_VEC;
          vec_rd_d = 1'b1;
        end else if (!img_fifo_empty) begin
          state_d  = S_POP_IMG;
          img_rd_d = 1'b1;
        end else if (finish_seen_q) begin
          state_d = S_TRAILER;
        end
      end
      S_POP_VEC: state_d = S_CAP_VEC;
      S_POP_IMG: state_d = S_CAP_IMG;
      S_CAP_VEC, S_CAP_IMG: begin
        state_d = S_SEND;
        ld      = 1'b1;
        ld_data = cap_word;
        wtype_d = (state_q == S_CAP_VEC) ? WT_VEC : WT_PIX;
        if (!tag_valid_q) begin
          frame_tag_d = cap_img;
          tag_valid_d = 1'b1;
        end
`ifdef ME_READER_TAG_CHECK_EN
        else if (cap_img != frame_tag_q) begin
          tag_err_d = 1'b1;
          ld        = 1'b0;
          state_d   = S_ARB;
        end
`endif
      end
      S_TRAILER: begin
        state_d = S_SEND;
        ld      = 1'b1;
        ld_eop  = 1'b1;
        ld_data = {WT_TRL, frame_tag_q, vec_cnt_q, px_cnt_q};
        wtype_d = WT_TRL;
      end
      S_SEND: begin
        if (fire) begin
          sop_pending_d = 1'b0;
          if (wtype_q == WT_TRL) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ARB;
            if (wtype_q == WT_VEC) vec_cnt_d = sat_inc(vec_cnt_q);
            else                   px_cnt_d  = sat_inc(px_cnt_q);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_fsm or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vec_rd_q      <= 1'b0;
      img_rd_q      <= 1'b0;
      vec_cnt_q     <= '0;
      px_cnt_q      <= '0;
      frame_tag_q   <= 2'b00;
      wtype_q       <= 2'b00;
      tag_valid_q   <= 1'b0;
      sop_pending_q <= 1'b0;
      finish_seen_q <= 1'b0;
`ifdef ME_READER_TAG_CHECK_EN
      tag_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      vec_rd_q      <= vec_rd_d;
      img_rd_q      <= img_rd_d;
      vec_cnt_q     <= vec_cnt_d;
      px_cnt_q      <= px_cnt_d;
      frame_tag_q   <= frame_tag_d;
      wtype_q       <= wtype_d;
      tag_valid_q   <= tag_valid_d;
      sop_pending_q <= sop_pending_d;
      finish_seen_q <= finish_seen_d;
`ifdef ME_READER_TAG_CHECK_EN
      tag_err_q     <= tag_err_d;
`endif
    end
  end

  me_out_stage u_out_stage (
    .clk_fsm   (clk_fsm),
    .rst_n     (rst_n),
    .load      (ld),
    .load_data (ld_data),
    .load_sop  (sop_pending_q),
    .load_eop  (ld_eop),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .fire      (fire)
  );

  assign vec_fifo_rd_req = vec_rd_q;
  assign img_fifo_rd_req = img_rd_q;
  assign vec_count       = vec_cnt_q;
  assign px_count        = px_cnt_q;
  assign idle            = (state_q == S_IDLE);
`ifdef ME_READER_TAG_CHECK_EN
  assign tag_err         = tag_err_q;
`else
  assign tag_err         = 1'b0;
`endif

endmodule
